// File: rtl/mult_serial_param.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// The multiplier is held in B and consumed LSB first. Partial products
// accumulate in {X,A}. In two's-complement mode the top multiplier bit has
// negative weight, so its partial product is subtracted instead of added.
// The final product appears as {Aval,Bval}.
module mult_serial_param #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             ClearA_LoadB,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ADD,
      ST_SUB,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             x_q, x_d;
   logic             mode_q, mode_d;
   logic [CW-1:0]    count_q, count_d;

   // Operands widened by one bit. ADD follows the mode; SUB is only reached
   // in signed mode, so it always sign-extends.
   logic [WIDTH:0]   a_add_ext, s_add_ext;
   logic [WIDTH:0]   a_sext, s_sext;
   logic [WIDTH:0]   add_sum, sub_diff;

   // Widen operands and form the sum and difference used by ADD and SUB.
   always_comb begin
      a_add_ext = mode_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
      s_add_ext = mode_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
      a_sext    = {a_q[WIDTH-1], a_q};
      s_sext    = {s_q[WIDTH-1], s_q};
      add_sum   = a_add_ext + s_add_ext;
      sub_diff  = a_sext - s_sext;
   end

   // Next-state and datapath update for the control sequence.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      x_d     = x_q;
      mode_d  = mode_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (Run) begin
               s_d     = Din;
               mode_d  = Signed;
               a_d     = '0;
               x_d     = 1'b0;
               count_d = '0;
               state_d = ST_CHECK;
            end else if (ClearA_LoadB) begin
               a_d = '0;
               x_d = 1'b0;
               b_d = Din;
            end
         end
         ST_CHECK: begin
            if (count_q == CNT_FULL)
               state_d = ST_DONE;
            else if (b_q[0] && mode_q && (count_q == CNT_LAST))
               state_d = ST_SUB;
            else if (b_q[0])
               state_d = ST_ADD;
            else
               state_d = ST_SHIFT;
         end
         ST_ADD: begin
            {x_d, a_d} = add_sum;
            state_d    = ST_SHIFT;
         end
         ST_SUB: begin
            {x_d, a_d} = sub_diff;
            state_d    = ST_SHIFT;
         end
         ST_SHIFT: begin
            a_d     = {x_q, a_q[WIDTH-1:1]};
            b_d     = {a_q[0], b_q[WIDTH-1:1]};
            x_d     = mode_q ? x_q : 1'b0;
            count_d = count_q + CW'(1);
            state_d = ST_CHECK;
         end
         ST_DONE: begin
            if (!Run)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset wins over everything.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         x_q     <= 1'b0;
         mode_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         x_q     <= x_d;
         mode_q  <= mode_d;
         count_q <= count_d;
      end
   end

   assign Aval = a_q;
   assign Bval = b_q;
   assign X    = x_q;
   assign Busy = (state_q == ST_CHECK) || (state_q == ST_ADD) ||
                 (state_q == ST_SUB)   || (state_q == ST_SHIFT);
   assign Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mult_serial_param.sv
// Directed bench for mult_serial_param at WIDTH=8 and WIDTH=4.
module tb_mult_serial_param;

   logic       Clk = 1'b0;
   logic       rst;

   logic       run8, clr8, sgn8;
   logic [7:0] din8, aval8, bval8;
   logic       x8, busy8, done8;

   logic       run4, clr4, sgn4;
   logic [3:0] din4, aval4, bval4;
   logic       x4, busy4, done4;

   int test_cnt = 0;
   int fail_cnt = 0;
   int n;

   always #5 Clk = ~Clk;

   mult_serial_param #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Reset(rst), .Run(run8), .ClearA_LoadB(clr8), .Signed(sgn8),
      .Din(din8), .Aval(aval8), .Bval(bval8), .X(x8), .Busy(busy8), .Done(done8)
   );

   mult_serial_param #(.WIDTH(4)) dut4 (
      .Clk(Clk), .Reset(rst), .Run(run4), .ClearA_LoadB(clr4), .Signed(sgn4),
      .Din(din4), .Aval(aval4), .Bval(bval4), .X(x4), .Busy(busy4), .Done(done4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Counts edges until Done, bounded so a stuck design still ends the run.
   task automatic wait8(output int cyc);
      cyc = 0;
      while (!done8 && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait4(output int cyc);
      cyc = 0;
      while (!done4 && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask

   task automatic load8(input logic [7:0] b);
      run8 = 1'b0; clr8 = 1'b1; din8 = b;
      tick();
      clr8 = 1'b0;
   endtask

   task automatic start8(input logic [7:0] s, input logic sg);
      run8 = 1'b1; din8 = s; sgn8 = sg;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      run8 = 0; clr8 = 0; sgn8 = 0; din8 = 8'h00;
      run4 = 0; clr4 = 0; sgn4 = 0; din4 = 4'h0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_aval8", aval8, 0);
      chk("rst_bval8", bval8, 0);
      chk("rst_x8",    x8,    0);
      chk("rst_busy4", busy4, 0);
      chk("rst_bval4", bval4, 0);

      // Signed -3 * 7 = -21; inputs scrambled while busy must be ignored
      load8(8'hFD);
      chk("load_bval", bval8, 8'hFD);
      chk("load_aval", aval8, 8'h00);
      start8(8'h07, 1'b1);
      chk("s1_busy", busy8, 1);
      din8 = 8'hAA; clr8 = 1'b1; sgn8 = 1'b0;
      wait8(n);
      chk("s1_cycles", n, 24);
      chk("s1_aval", aval8, 8'hFF);
      chk("s1_bval", bval8, 8'hEB);
      chk("s1_busy_done", busy8, 0);

      // Run still high: stay in DONE with registers frozen
      tick(); tick(); tick();
      chk("hold_done", done8, 1);
      chk("hold_aval", aval8, 8'hFF);
      chk("hold_bval", bval8, 8'hEB);

      // Drop Run, then restart: multiplier is the previous low half (-21 * 2)
      clr8 = 1'b0; run8 = 1'b0;
      tick();
      chk("idle_done", done8, 0);
      chk("idle_busy", busy8, 0);
      start8(8'h02, 1'b1);
      run8 = 1'b0;
      wait8(n);
      chk("rs_cycles", n, 23);
      chk("rs_aval", aval8, 8'hFF);
      chk("rs_bval", bval8, 8'hD6);

      // Unsigned 255 * 255 = 0xFE01
      tick();
      load8(8'hFF);
      start8(8'hFF, 1'b0);
      run8 = 1'b0;
      wait8(n);
      chk("u_cycles", n, 25);
      chk("u_aval", aval8, 8'hFE);
      chk("u_bval", bval8, 8'h01);
      chk("u_x", x8, 0);

      // Signed corner -128 * -128 = 16384, last bit goes through SUB
      tick();
      load8(8'h80);
      start8(8'h80, 1'b1);
      run8 = 1'b0;
      wait8(n);
      chk("c_cycles", n, 18);
      chk("c_aval", aval8, 8'h40);
      chk("c_bval", bval8, 8'h00);

      // Reset during the fifth cycle of a multiply
      tick();
      load8(8'h05);
      start8(8'h03, 1'b0);
      run8 = 1'b0;
      tick(); tick(); tick(); tick();
      chk("mid_busy_pre", busy8, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_busy", busy8, 0);
      chk("mid_done", done8, 0);
      chk("mid_aval", aval8, 0);
      chk("mid_bval", bval8, 0);
      chk("mid_x",    x8,    0);
      tick();
      chk("mid_idle", busy8, 0);
      load8(8'h05);
      start8(8'h03, 1'b0);
      run8 = 1'b0;
      wait8(n);
      chk("post_cycles", n, 19);
      chk("post_aval", aval8, 8'h00);
      chk("post_bval", bval8, 8'h0F);

      // WIDTH=4: signed -7 * 3 = -21
      clr4 = 1'b1; din4 = 4'h9;
      tick();
      clr4 = 1'b0;
      chk("w4_load", bval4, 4'h9);
      run4 = 1'b1; din4 = 4'h3; sgn4 = 1'b1;
      tick();
      run4 = 1'b0;
      wait4(n);
      chk("w4_cycles", n, 11);
      chk("w4_aval", aval4, 4'hE);
      chk("w4_bval", bval4, 4'hB);
      chk("w4_done", done4, 1);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
